// File: rtl/fetch_redirect.sv
// Fetch-stage PC register with taken-branch redirect and a timed pipeline flush.
// A taken branch from the resolve stage reloads the PC with the word-aligned target.
// Flush is then held for FLUSH_CYCLES cycles so that the wrong-path instructions
// already in IF/ID and ID/EX are squashed. While the flush is in progress,
// further PCSrc pulses come from wrong-path instructions and are ignored.
module fetch_redirect #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        PCSrc,
    input  logic [31:0] BranchTarget,
    input  logic        Stall,
    output logic [31:0] PC,
    output logic [31:0] PCPlus4,
    output logic        Flush,
    output logic        Redirecting,
    output logic        Misalign,
    output logic [15:0] TakenCount
);

    typedef enum logic [0:0] {StRun, StFlush} state_e;

    // Extra cycles spent in StFlush after the redirect cycle itself.
    localparam logic [2:0] FlushLoad  = 3'(FLUSH_CYCLES - 1);
    localparam bit         MultiCycle = (FLUSH_CYCLES > 1);

    state_e      state_q, state_d;
    logic [2:0]  flush_cnt_q, flush_cnt_d;
    logic [31:0] pc_q, pc_d;
    logic        misalign_q, misalign_d;
    logic [15:0] taken_cnt_q, taken_cnt_d;
    logic [31:0] pc_plus4;
    logic        accept;

    // Redirect acceptance: only the RUN state trusts PCSrc.
    always_comb begin
        accept   = (state_q == StRun) && PCSrc;
        pc_plus4 = pc_q + 32'd4;
    end

    // State register and flush down-counter.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q     <= StRun;
            flush_cnt_q <= 3'd0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // Next-state logic: the counter runs regardless of Stall.
    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        unique case (state_q)
            StRun: begin
                if (accept && MultiCycle) begin
                    state_d     = StFlush;
                    flush_cnt_d = FlushLoad;
                end
            end
            StFlush: begin
                flush_cnt_d = flush_cnt_q - 3'd1;
                // The <= comparison keeps a corrupted zero count from trapping the FSM.
                if (flush_cnt_q <= 3'd1) begin
                    state_d     = StRun;
                    flush_cnt_d = 3'd0;
                end
            end
            default: begin
                state_d     = StRun;
                flush_cnt_d = 3'd0;
            end
        endcase
    end

    // FSM outputs: Flush covers the redirect cycle plus every StFlush cycle.
    always_comb begin
        Flush       = accept || (state_q == StFlush);
        Redirecting = (state_q == StFlush);
    end

    // Datapath register: PC, sticky misalign flag, and the redirect counter.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            pc_q        <= RESET_PC;
            misalign_q  <= 1'b0;
            taken_cnt_q <= 16'd0;
        end else begin
            pc_q        <= pc_d;
            misalign_q  <= misalign_d;
            taken_cnt_q <= taken_cnt_d;
        end
    end

    // Datapath next-state logic: a redirect wins over Stall.
    always_comb begin
        if (accept) begin
            pc_d = {BranchTarget[31:2], 2'b00};
        end else if (Stall) begin
            pc_d = pc_q;
        end else begin
            pc_d = pc_plus4;
        end

        misalign_d = misalign_q || (accept && (BranchTarget[1:0] != 2'b00));

        taken_cnt_d = taken_cnt_q;
        if (accept && (taken_cnt_q != 16'hFFFF)) begin
            taken_cnt_d = taken_cnt_q + 16'd1;
        end
    end

    // Output drive from the datapath registers.
    always_comb begin
        PC         = pc_q;
        PCPlus4    = pc_plus4;
        Misalign   = misalign_q;
        TakenCount = taken_cnt_q;
    end

endmodule
